serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add WIDTH-bit operands LSB-first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that computes a-b with cout as the no-borrow flag.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
            $error("serial_adder: WIDTH must be in 2..64");
        end
    endgenerate

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] shreg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             cnext;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH-1:0] shreg_next;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign s          = opa[0] ^ opb[0] ^ carry;
    assign cnext      = majority(opa[0], opb[0], carry);
    assign shreg_next = {s, shreg[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            shreg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    opa   <= {1'b0, opa[WIDTH-1:1]};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    shreg <= shreg_next;
                    carry <= cnext;
                    cnt   <= cnt + 1'b1;
                    // Final bit: publish the result on this same edge.
                    if (cnt == LAST) begin
                        sum   <= shreg_next;
                        cout  <= cnext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_chk;
    int n_fail;

    // Result the DUT should currently be holding.
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xc, input logic xsub,
                         output logic [WIDTH-1:0] es, output logic ec);
        int unsigned total;
        if (xsub)
            total = int'(xa) + ((1 << WIDTH) - 1 - int'(xb)) + 1;
        else
            total = int'(xa) + int'(xb) + int'(xc);
        es = total[WIDTH-1:0];
        ec = total[WIDTH];
    endtask

    // Accept one operation and follow it to its done pulse. glitch>0 pulses start
    // (with a different 'a') at that SHIFT cycle to confirm it is ignored.
    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xc, input logic xsub, input int glitch, input string tag);
        logic [WIDTH-1:0] es;
        logic             ec;
        model(xa, xb, xc, xsub, es, ec);
        start = 1'b1;
        a     = xa;
        b     = xb;
        cin   = xc;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = xsub;
`endif
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        chk({tag, ".busy_accept"}, 64'(busy), 64'(1));
        chk({tag, ".done_accept"}, 64'(done), 64'(0));
        for (int k = 1; k < WIDTH; k++) begin
            if (k == glitch) begin
                start = 1'b1;
                a     = 8'h11;
            end else begin
                start = 1'b0;
            end
            tick();
            chk({tag, ".busy_shift"}, 64'(busy), 64'(1));
            chk({tag, ".done_shift"}, 64'(done), 64'(0));
            chk({tag, ".sum_held"}, 64'(sum), 64'(held_sum));
            chk({tag, ".cout_held"}, 64'(cout), 64'(held_cout));
        end
        start = 1'b0;
        tick();
        held_sum  = es;
        held_cout = ec;
        chk({tag, ".done"}, 64'(done), 64'(1));
        chk({tag, ".busy_done"}, 64'(busy), 64'(0));
        chk({tag, ".sum"}, 64'(sum), 64'(es));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
    endtask

    task automatic idle_check(input string tag);
        start = 1'b0;
        tick();
        chk({tag, ".done_fall"}, 64'(done), 64'(0));
        chk({tag, ".busy_idle"}, 64'(busy), 64'(0));
        chk({tag, ".sum_keep"}, 64'(sum), 64'(held_sum));
        chk({tag, ".cout_keep"}, 64'(cout), 64'(held_cout));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        n_chk     = 0;
        n_fail    = 0;
        held_sum  = '0;
        held_cout = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #2;
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.sum", 64'(sum), 64'(0));
        chk("reset.cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(8'h00, 8'h00, 1'b0, 1'b0, 0, "zero");
        idle_check("zero");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "ff_1");
        idle_check("ff_1");
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0, "a5_5a");
        // Back-to-back: start driven during the DONE cycle.
        do_op(8'h03, 8'h04, 1'b0, 1'b0, 0, "b2b");
        idle_check("b2b");
        do_op(8'h22, 8'h33, 1'b0, 1'b0, 3, "ignored_start");
        idle_check("ignored_start");

        // Abort mid-SHIFT with an asynchronous reset.
        start = 1'b1;
        a     = 8'h44;
        b     = 8'h55;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        held_sum  = '0;
        held_cout = 1'b0;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.done", 64'(done), 64'(0));
        chk("abort.sum", 64'(sum), 64'(0));
        chk("abort.cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 2; k++) begin
            tick();
            chk("abort.no_done", 64'(done), 64'(0));
        end
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 0, "after_abort");
        idle_check("after_abort");

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, 1'b0, 0, "rand");
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end

`ifdef SERIAL_ADDER_SUB_EN
        idle_check("pre_sub");
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_5_7");
        do_op(8'h07, 8'h05, 1'b1, 1'b1, 0, "sub_7_5");
        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, 1'($urandom), 0, "rand_sub");
        end
        idle_check("sub_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
